mmio_uart_tx: RTL and testbench

- Memory-mapped serial transmit peripheral on the processor's data-memory bus, alongside dmem.
- Snoops address_dmem/data/wren from the processor.
- Bytes written to a fixed data address are queued in a FIFO and shifted out as 8N1 UART frames.
- A status word lets software poll FIFO state and overflow.

---
 rtl/mmio_uart_tx.sv | 174 +++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO and status word
// Snoops processor stores: DATA_ADDR queues a byte, STATUS_ADDR with data[0]=1 clears overflow.
module mmio_uart_tx #(
    parameter logic [11:0] DATA_ADDR    = 12'hFF0,
    parameter logic [11:0] STATUS_ADDR  = 12'hFF1,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] status,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int TICK_W = 16;
    localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state, state_next;
    logic [TICK_W-1:0]   tick, tick_next;
    logic [2:0]          bit_idx, bit_idx_next;
    logic [7:0]          shift, shift_next;
    logic                tx_next;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    count;
    logic [31:0]         status_next;

    logic push_req, clear_req, pop, full, empty, push_ok, drop, last_tick;
    logic unused_data_bits;

    assign unused_data_bits = ^data[31:8];

    assign push_req  = wren && (address_dmem == DATA_ADDR);
    assign clear_req = wren && (address_dmem == STATUS_ADDR) && data[0];
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign pop       = (state == IDLE) && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO is still taken.
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && !push_ok;
    assign last_tick = (tick == LAST_TICK);

    assign busy = (state != IDLE) | (count != '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            tick    <= tick_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    always_comb begin
        state_next   = state;
        tick_next    = tick;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_next = START;
                    tick_next  = '0;
                    shift_next = mem[rd_ptr];
                end
            end
            START: begin
                if (last_tick) begin
                    state_next   = DATA;
                    tick_next    = '0;
                    bit_idx_next = '0;
                end else begin
                    tick_next = tick + TICK_W'(1);
                end
            end
            DATA: begin
                if (last_tick) begin
                    tick_next  = '0;
                    shift_next = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    tick_next = tick + TICK_W'(1);
                end
            end
            STOP: begin
                if (last_tick) begin
                    state_next = IDLE;
                    tick_next  = '0;
                end else begin
                    tick_next = tick + TICK_W'(1);
                end
            end
        endcase
    end

    // tx is registered from the next-state view so the line changes on the same edge as the FSM.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= data[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_req) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        status_next = {19'd0, 5'(count), 4'd0, overflow, (state != IDLE), empty, full};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            status <= 32'h0000_0002;
        end else begin
            status <= status_next;
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a queue-based line model
module tb_mmio_uart_tx;
    localparam int CPB = 4;
    localparam int DEPTH = 4;
    localparam logic [11:0] A_DATA = 12'hFF0;
    localparam logic [11:0] A_STAT = 12'hFF1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        wren = 1'b0;
    logic [11:0] address_dmem = 12'h000;
    logic [31:0] data = 32'h0;
    logic [31:0] status;
    logic        tx, busy, overflow;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  m_fifo[$];
    bit          m_line[$];
    logic        m_ovf;
    logic [31:0] m_status;

    mmio_uart_tx #(
        .DATA_ADDR(A_DATA), .STATUS_ADDR(A_STAT), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data),
        .wren(wren), .status(status), .tx(tx), .busy(busy), .overflow(overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic exp_tx();
        return (m_line.size() == 0) ? 1'b1 : m_line[0];
    endfunction

    function automatic logic exp_busy();
        return (m_line.size() != 0) || (m_fifo.size() != 0);
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_line.delete();
        m_ovf = 1'b0;
        m_status = 32'h0000_0002;
    endtask

    // One clock edge of the model: the line queue holds one entry per remaining cycle of the frame.
    task automatic model_edge(input logic w, input logic [11:0] a, input logic [31:0] d);
        bit active, do_pop, pre_full, v;
        logic [7:0] b;
        pre_full = (m_fifo.size() == DEPTH);
        active   = (m_line.size() != 0);
        m_status = {19'd0, 5'(m_fifo.size()), 4'd0, m_ovf, active, (m_fifo.size() == 0), pre_full};
        do_pop   = !active && (m_fifo.size() != 0);
        if (active) void'(m_line.pop_front());
        if (do_pop) begin
            b = m_fifo.pop_front();
            for (int k = 0; k < 10; k++) begin
                v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                repeat (CPB) m_line.push_back(v);
            end
        end
        if (w && a == A_DATA) begin
            if (!pre_full || do_pop) m_fifo.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end else if (w && a == A_STAT && d[0]) begin
            m_ovf = 1'b0;
        end
    endtask

    task automatic drive_cycle(input logic w, input logic [11:0] a, input logic [31:0] d);
        wren = w; address_dmem = a; data = d;
        @(posedge clock);
        model_edge(w, a, d);
        #1;
        wren = 1'b0; address_dmem = 12'h000; data = 32'h0;
    endtask

    task automatic test_reset();
        #3; reset = 1'b1; model_reset(); #1;
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx got %b want 1", tx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_vec++; if (status !== 32'h2) begin n_err++; $display("FAIL reset_status got %h want 00000002", status); end
        @(posedge clock); #1; reset = 1'b0;
    endtask

    task automatic test_single();
        logic [9:0] frame;
        frame = {1'b1, 8'hA5, 1'b0};
        drive_cycle(1'b1, A_DATA, 32'h0000_00A5);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_push got %b want 1", busy); end
        for (int c = 1; c <= 41; c++) begin
            drive_cycle(1'b0, 12'h000, 32'h0);
            n_vec++; if (tx !== exp_tx()) begin n_err++; $display("FAIL single_tx_model c=%0d got %b want %b", c, tx, exp_tx()); end
            if (c <= 40) begin
                n_vec++; if (tx !== frame[(c-1)/CPB]) begin n_err++; $display("FAIL single_tx_bit c=%0d got %b want %b", c, tx, frame[(c-1)/CPB]); end
            end
            n_vec++; if (busy !== (c < 41)) begin n_err++; $display("FAIL single_busy c=%0d got %b want %b", c, busy, (c < 41)); end
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) drive_cycle(1'b1, A_DATA, 32'(i) | ($urandom & 32'hFFFF_FF00));
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        drive_cycle(1'b0, 12'h000, 32'h0);
        n_vec++; if (status[3] !== 1'b1) begin n_err++; $display("FAIL ovf_status_bit3 got %b want 1", status[3]); end
        n_vec++; if (status[0] !== 1'b1) begin n_err++; $display("FAIL ovf_status_bit0 got %b want 1", status[0]); end
        n_vec++; if (status[12:8] !== 5'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", status[12:8]); end
        for (int c = 0; c < 5 * 41 + 5; c++) begin
            drive_cycle(1'b0, 12'h000, 32'h0);
            n_vec++; if (tx !== exp_tx()) begin n_err++; $display("FAIL ovf_tx c=%0d got %b want %b", c, tx, exp_tx()); end
            n_vec++; if (busy !== exp_busy()) begin n_err++; $display("FAIL ovf_busy c=%0d got %b want %b", c, busy, exp_busy()); end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ovf_drained got %b want 0", busy); end
    endtask

    task automatic test_clear();
        drive_cycle(1'b1, A_STAT, 32'h0);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clear_zero_write got %b want 1", overflow); end
        drive_cycle(1'b1, A_STAT, 32'hFFFF_FFFE);
        n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL clear_bit0_low got %b want 1", overflow); end
        drive_cycle(1'b1, 12'h010, 32'h0000_00FF);
        drive_cycle(1'b0, A_DATA, 32'h0000_0077);
        drive_cycle(1'b0, 12'h000, 32'h0);
        n_vec++; if (status[12:8] !== 5'd0) begin n_err++; $display("FAIL clear_other_addr_count got %0d want 0", status[12:8]); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL clear_other_addr_busy got %b want 0", busy); end
        drive_cycle(1'b1, A_STAT, 32'h1);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL clear_flag got %b want 0", overflow); end
        drive_cycle(1'b0, 12'h000, 32'h0);
        n_vec++; if (status[3] !== 1'b0) begin n_err++; $display("FAIL clear_status_bit3 got %b want 0", status[3]); end
    endtask

    task automatic test_push_pop_full();
        int i;
        for (int k = 0; k < 5; k++) drive_cycle(1'b1, A_DATA, $urandom);
        drive_cycle(1'b0, 12'h000, 32'h0);
        n_vec++; if (status[12:8] !== 5'd4) begin n_err++; $display("FAIL ppf_fill_count got %0d want 4", status[12:8]); end
        for (i = 0; i < 100 && m_line.size() != 0; i++) begin
            drive_cycle(1'b0, 12'h000, 32'h0);
            n_vec++; if (tx !== exp_tx()) begin n_err++; $display("FAIL ppf_tx got %b want %b", tx, exp_tx()); end
        end
        n_vec++; if (i >= 100) begin n_err++; $display("FAIL ppf_wait_frame got timeout want frame end"); end
        drive_cycle(1'b1, A_DATA, $urandom);
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ppf_overflow got %b want 0", overflow); end
        drive_cycle(1'b0, 12'h000, 32'h0);
        n_vec++; if (status[12:8] !== 5'd4) begin n_err++; $display("FAIL ppf_count got %0d want 4", status[12:8]); end
        for (i = 0; i < 400 && exp_busy(); i++) begin
            drive_cycle(1'b0, 12'h000, 32'h0);
            n_vec++; if (tx !== exp_tx()) begin n_err++; $display("FAIL ppf_drain_tx got %b want %b", tx, exp_tx()); end
            n_vec++; if (busy !== exp_busy()) begin n_err++; $display("FAIL ppf_drain_busy got %b want %b", busy, exp_busy()); end
        end
    endtask

    task automatic test_reset_midframe();
        int i;
        logic [9:0] frame;
        frame = {1'b1, 8'h3C, 1'b0};
        drive_cycle(1'b1, A_DATA, 32'h5A);
        drive_cycle(1'b1, A_DATA, 32'h11);
        drive_cycle(1'b1, A_DATA, 32'h22);
        for (i = 0; i < 100 && m_line.size() != 22; i++) drive_cycle(1'b0, 12'h000, 32'h0);
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_bit3 got %b want 1", tx); end
        #3; reset = 1'b1; model_reset(); #1;
        n_vec++; if (tx !== 1'b1) begin n_err++; $display("FAIL midrst_tx got %b want 1", tx); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_vec++; if (status !== 32'h2) begin n_err++; $display("FAIL midrst_status got %h want 00000002", status); end
        @(posedge clock); #1; reset = 1'b0;
        drive_cycle(1'b1, A_DATA, 32'h0000_003C);
        for (int c = 1; c <= 41; c++) begin
            drive_cycle(1'b0, 12'h000, 32'h0);
            n_vec++; if (tx !== exp_tx()) begin n_err++; $display("FAIL midrst_tx_model c=%0d got %b want %b", c, tx, exp_tx()); end
            if (c <= 40) begin
                n_vec++; if (tx !== frame[(c-1)/CPB]) begin n_err++; $display("FAIL midrst_tx_bit c=%0d got %b want %b", c, tx, frame[(c-1)/CPB]); end
            end
        end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_done got %b want 0", busy); end
    endtask

    task automatic test_random();
        int r;
        logic [11:0] a;
        logic w;
        for (int c = 0; c < 900; c++) begin
            r = $urandom_range(0, 19);
            w = 1'b1;
            if (r < 3) a = A_DATA;
            else if (r == 3) a = A_STAT;
            else if (r == 4) a = 12'($urandom_range(0, 12'hFEF));
            else begin w = (r == 5); a = (r == 6) ? A_DATA : 12'h000; if (r == 6) w = 1'b0; end
            drive_cycle(w, a, $urandom);
            n_vec++; if (tx !== exp_tx()) begin n_err++; $display("FAIL rnd_tx c=%0d got %b want %b", c, tx, exp_tx()); end
            n_vec++; if (busy !== exp_busy()) begin n_err++; $display("FAIL rnd_busy c=%0d got %b want %b", c, busy, exp_busy()); end
            n_vec++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow c=%0d got %b want %b", c, overflow, m_ovf); end
            n_vec++; if (status !== m_status) begin n_err++; $display("FAIL rnd_status c=%0d got %h want %h", c, status, m_status); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_overflow();
        test_clear();
        test_push_pop_full();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
